// File: rtl/seg7_pkg.sv
// Shared types and the hex glyph table for the seven-segment scan driver.
// Glyphs are stored active-low in g,f,e,d,c,b,a order (bit 6 = g).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  localparam seg7_t GLYPHS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,  // 8 9 A b
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side and pin-side signals of the seven-segment scan driver.
// master drives value/load/dp/blank; slave (the driver) drives the pins.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_i;
  logic                    load_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic [6:0]              seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   an_o;

  modport master (
    output value_i, load_i, dp_i, blank_i,
    input  seg_o, dp_o, an_o
  );

  modport slave (
    input  value_i, load_i, dp_i, blank_i,
    output seg_o, dp_o, an_o
  );
endinterface

// File: rtl/seg7_font.sv
// Combinational hex-nibble to active-low seven-segment glyph lookup.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg7_t      seg_o
);
  assign seg_o = GLYPHS[hex_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with a dead cycle per slot.
// Define SEG7_LZ_SUPPRESS_EN to darken leading zero digits (digit 0 always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 6750,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit AN_ACTIVE_LOW   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(TICKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam seg7_t                 SEG_DARK = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_DARK  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_DARK  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpsh_q, dpsh_d;
  seg7_t                   seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0]            sel_hex;
  seg7_t                 glyph;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  dark;

  assign sel_hex = val_q[{idx_q, 2'b00} +: 4];

  seg7_font u_font (
    .hex_i (sel_hex),
    .seg_o (glyph)
  );

`ifdef SEG7_LZ_SUPPRESS_EN
  // Walk down from the top digit; a digit is dark while every digit above it is zero too.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign onehot = NUM_DIGITS'(1) << idx_q;
  assign dark   = bus.blank_i[idx_q] | lz_mask[idx_q];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    val_d  = val_q;
    dpsh_d = dpsh_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    an_d   = an_q;

    if (bus.load_i) begin
      val_d  = bus.value_i;
      dpsh_d = bus.dp_i;
    end

    if (cnt_q == CNT_LAST) begin
      // Slot end: everything goes dark for the anti-ghosting dead cycle.
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      seg_d = SEG_DARK;
      dp_d  = DP_DARK;
      an_d  = AN_DARK;
    end else if (cnt_q == '0) begin
      if (dark) begin
        seg_d = SEG_DARK;
        dp_d  = DP_DARK;
        an_d  = AN_DARK;
      end else begin
        seg_d = SEG_ACTIVE_LOW ? glyph : ~glyph;
        dp_d  = SEG_ACTIVE_LOW ? ~dpsh_q[idx_q] : dpsh_q[idx_q];
        an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dpsh_q <= '0;
      seg_q  <= SEG_DARK;
      dp_q   <= DP_DARK;
      an_q   <= AN_DARK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      dpsh_q <= dpsh_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign bus.seg_o = seg_q;
  assign bus.dp_o  = dp_q;
  assign bus.an_o  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4 ticks per slot, active-low pins.
// Expectations follow SEG7_LZ_SUPPRESS_EN when it is defined for the build.
module tb_seg7_scan_driver;

`ifdef SEG7_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] OFF = 7'h7F;
  localparam logic [6:0] G0  = 7'b1000000;
  localparam logic [6:0] G1  = 7'b1111001;
  localparam logic [6:0] G2  = 7'b0100100;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] GE  = 7'b0000110;
  localparam logic [6:0] GF  = 7'b0001110;
  localparam logic [3:0] AN0 = 4'b1110;
  localparam logic [3:0] AN1 = 4'b1101;
  localparam logic [3:0] AN2 = 4'b1011;
  localparam logic [3:0] AN3 = 4'b0111;
  localparam logic [3:0] ANX = 4'b1111;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS      (4),
    .TICKS_PER_DIGIT (4),
    .SEG_ACTIVE_LOW  (1'b1),
    .AN_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] es, input logic ed, input logic [3:0] ea);
    n_vec++;
    assert (bus.seg_o === es && bus.dp_o === ed && bus.an_o === ea) else begin
      n_err++;
      $error("FAIL %s: seg/dp/an = %b/%b/%b, expected %b/%b/%b",
             tag, bus.seg_o, bus.dp_o, bus.an_o, es, ed, ea);
    end
  endtask

  task automatic check_dead(input string tag);
    n_vec++;
    assert (bus.an_o === ANX) else begin
      n_err++;
      $error("FAIL %s: an = %b, expected %b", tag, bus.an_o, ANX);
    end
  endtask

  // Entered on the dead cycle of a slot; checks its three lit cycles and the next dead cycle.
  task automatic scan_slot(input string tag, input logic [6:0] es, input logic ed, input logic [3:0] ea);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(tag, es, ed, ea);
    end
    @(negedge clk);
    check_dead({tag, "_dead"});
  endtask

  // A zero digit that leading-zero suppression darkens when enabled.
  task automatic zero_slot(input string tag, input logic [3:0] ea);
    scan_slot(tag, LZ ? OFF : G0, 1'b1, LZ ? ANX : ea);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.value_i = '0;
    bus.load_i  = 1'b0;
    bus.dp_i    = '0;
    bus.blank_i = '0;

    repeat (2) @(negedge clk);
    check("reset", OFF, 1'b1, ANX);
    rst_n = 1'b1;
    check_dead("post_reset_dead");

    // First slot shows the reset shadow (0); a load mid-slot must not disturb it.
    @(negedge clk);
    check("d0_first", G0, 1'b1, AN0);
    bus.value_i = 16'h12EF;
    bus.load_i  = 1'b1;
    @(negedge clk);
    check("d0_after_load", G0, 1'b1, AN0);
    bus.load_i = 1'b0;
    @(negedge clk);
    check("d0_lit3", G0, 1'b1, AN0);
    @(negedge clk);
    check_dead("d1_dead");

    scan_slot("12EF_d1", GE, 1'b1, AN1);
    scan_slot("12EF_d2", G2, 1'b1, AN2);
    scan_slot("12EF_d3", G1, 1'b1, AN3);
    scan_slot("12EF_d0", GF, 1'b1, AN0);

    // Load 0000 while digit 1 is lit: digit 1 keeps E for the rest of its slot.
    @(negedge clk);
    check("ml_d1_a", GE, 1'b1, AN1);
    bus.value_i = 16'h0000;
    bus.load_i  = 1'b1;
    @(negedge clk);
    check("ml_d1_b", GE, 1'b1, AN1);
    bus.load_i = 1'b0;
    @(negedge clk);
    check("ml_d1_c", GE, 1'b1, AN1);
    @(negedge clk);
    check_dead("ml_d2_dead");

    zero_slot("z_d2", AN2);
    zero_slot("z_d3", AN3);
    scan_slot("z_d0", G0, 1'b1, AN0);
    zero_slot("z_d1", AN1);

    // Load on the 0->1 edge of digit 2: that slot still shows the old shadow.
    bus.value_i = 16'h12EF;
    bus.dp_i    = 4'b0001;
    bus.blank_i = 4'b0010;
    bus.load_i  = 1'b1;
    @(negedge clk);
    check("bl_d2_old_a", LZ ? OFF : G0, 1'b1, LZ ? ANX : AN2);
    bus.load_i = 1'b0;
    @(negedge clk);
    check("bl_d2_old_b", LZ ? OFF : G0, 1'b1, LZ ? ANX : AN2);
    @(negedge clk);
    check("bl_d2_old_c", LZ ? OFF : G0, 1'b1, LZ ? ANX : AN2);
    @(negedge clk);
    check_dead("bl_d3_dead");

    scan_slot("bl_d3", G1, 1'b1, AN3);
    scan_slot("bl_d0_dp", GF, 1'b0, AN0);
    scan_slot("bl_d1_blank", OFF, 1'b1, ANX);
    scan_slot("bl_d2", G2, 1'b1, AN2);

    // 0050: leading-zero behaviour on digits 3 and 2.
    bus.blank_i = '0;
    bus.dp_i    = '0;
    bus.value_i = 16'h0050;
    bus.load_i  = 1'b1;
    @(negedge clk);
    check("lz_d3_old_a", G1, 1'b1, AN3);
    bus.load_i = 1'b0;
    @(negedge clk);
    check("lz_d3_old_b", G1, 1'b1, AN3);
    @(negedge clk);
    check("lz_d3_old_c", G1, 1'b1, AN3);
    @(negedge clk);
    check_dead("lz_d0_dead");

    scan_slot("lz_d0", G0, 1'b1, AN0);
    scan_slot("lz_d1", G5, 1'b1, AN1);
    zero_slot("lz_d2", AN2);
    zero_slot("lz_d3", AN3);
    scan_slot("pre_rst_d0", G0, 1'b1, AN0);
    scan_slot("pre_rst_d1", G5, 1'b1, AN1);

    // Asynchronous reset in the middle of digit 2's slot.
    @(negedge clk);
    check("pre_rst_d2", LZ ? OFF : G0, 1'b1, LZ ? ANX : AN2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", OFF, 1'b1, ANX);
    @(negedge clk);
    check("held_reset", OFF, 1'b1, ANX);
    rst_n = 1'b1;
    check_dead("restart_dead");
    scan_slot("restart_d0", G0, 1'b1, AN0);
    zero_slot("restart_d1", AN1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
